// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers.
// The display controller and colour stage import the same blanking bounds,
// so every block agrees on where the visible window and sync pulses sit.
package vga_timing_gen_pkg;

   localparam int COORD_W  = 10;   // pixel coordinate width
   localparam int CNT_W    = 6;    // frame-counter width for blink signals

   localparam int H_VIS    = 640;
   localparam int V_VIS    = 480;
   localparam int H_TOT    = 800;
   localparam int V_TOT    = 525;
   localparam int HS_START = 656;
   localparam int HS_END   = 751;
   localparam int VS_START = 490;
   localparam int VS_END   = 491;

   typedef logic [COORD_W-1:0] coord_t;

   // Inclusive range test used for the sync windows.
   function automatic logic in_range(input coord_t v, input int lo, input int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_frame_toggle.sv
// frame_toggle: divides a one-clk tick stream by N and toggles q each time
// N ticks have been seen (q half-period = N ticks).
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - one-clk strobe, one per frame
//   q     - toggle output, 0 after reset
module frame_toggle
   import vga_timing_gen_pkg::*;
#(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   output logic q
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic             q_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         q_reg   <= 1'b0;
      end else if (tick) begin
         if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            q_reg   <= ~q_reg;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing plus frame-synchronous blink
// signals for the Pong display path.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   xpix/ypix  - current pixel column/line (10-bit)
//   hsync      - horizontal sync, active-low
//   vsync      - vertical sync, active-low
//   video_on   - high inside the visible window
//   pix_en     - one-clk pixel-advance strobe every PIX_DIV clocks
//   frame_tick - one-clk pulse on the (last,last)->(0,0) wrap
//   gmv_flash  - toggles every FLASH_FRAMES frames
//   flick      - toggles every FLICK_FRAMES frames
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int PIX_DIV      = 1,
   parameter int H_VIS        = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_VIS        = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int FLASH_FRAMES = 30,
   parameter int FLICK_FRAMES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [9:0]   xpix,
   output logic [9:0]   ypix,
   output logic         hsync,
   output logic         vsync,
   output logic         video_on,
   output logic         pix_en,
   output logic         frame_tick,
   output logic         gmv_flash,
   output logic         flick
);

   localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HS_FIRST = H_VIS + H_FP;
   localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
   localparam int VS_FIRST = V_VIS + V_FP;
   localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

   // A 1-bit divider is kept even for PIX_DIV=1 so widths stay legal.
   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam coord_t X_LAST = COORD_W'(H_TOTAL - 1);
   localparam coord_t Y_LAST = COORD_W'(V_TOTAL - 1);

   logic [DIV_W-1:0] div_reg, div_next;
   logic             pix_en_reg;
   coord_t           x_reg, x_next;
   coord_t           y_reg, y_next;
   logic             hsync_reg, vsync_reg, video_on_reg, frame_tick_reg;
   logic             frame_wrap;

   always_comb begin
      div_next   = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      x_next     = x_reg;
      y_next     = y_reg;
      frame_wrap = 1'b0;
      if (pix_en_reg) begin
         if (x_reg == X_LAST) begin
            x_next = '0;
            if (y_reg == Y_LAST) begin
               y_next     = '0;
               frame_wrap = 1'b1;
            end else begin
               y_next = y_reg + 1'b1;
            end
         end else begin
            x_next = x_reg + 1'b1;
         end
      end
   end

   // Sync and video_on are decoded from the next coordinates so they land in
   // the same edge as the counters (zero relative latency). They only load on
   // pixel advances, which is what leaves pixel (0,0) blanked after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg        <= '0;
         pix_en_reg     <= 1'b0;
         x_reg          <= '0;
         y_reg          <= '0;
         hsync_reg      <= 1'b1;
         vsync_reg      <= 1'b1;
         video_on_reg   <= 1'b0;
         frame_tick_reg <= 1'b0;
      end else begin
         div_reg        <= div_next;
         pix_en_reg     <= (div_next == DIV_LAST);
         frame_tick_reg <= frame_wrap;
         if (pix_en_reg) begin
            x_reg        <= x_next;
            y_reg        <= y_next;
            hsync_reg    <= ~in_range(x_next, HS_FIRST, HS_LAST);
            vsync_reg    <= ~in_range(y_next, VS_FIRST, VS_LAST);
            video_on_reg <= (int'(x_next) < H_VIS) && (int'(y_next) < V_VIS);
         end
      end
   end

   // Blink toggles are driven by the wrap strobe itself so they change in the
   // very clk where frame_tick rises, never inside a visible frame.
   frame_toggle #(.N(FLASH_FRAMES)) u_flash (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (frame_wrap),
      .q     (gmv_flash)
   );

   frame_toggle #(.N(FLICK_FRAMES)) u_flick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (frame_wrap),
      .q     (flick)
   );

   assign xpix       = x_reg;
   assign ypix       = y_reg;
   assign hsync      = hsync_reg;
   assign vsync      = vsync_reg;
   assign video_on   = video_on_reg;
   assign pix_en     = pix_en_reg;
   assign frame_tick = frame_tick_reg;

endmodule
